// File: rtl/m707.sv
// m707 - teletype transmitter stage (PDP-8/I console).
// Shifts an accepted character out as an 11-unit asynchronous frame
// (start, 8 data LSB first, 2 stops) and raises the printer flag at
// frame completion. Every output comes straight from a register.
module m707 #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       clear_flag,
    output logic       serial_out,
    output logic       busy,
    output logic       flag
);

    // A bit time shorter than two clocks cannot be represented by the timer.
    if (CLKS_PER_BIT < 2) begin : g_cfg_check
        $error("m707: CLKS_PER_BIT must be at least 2");
    end

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state, w_state_n;
    logic [TW-1:0]   r_timer, w_timer_n;
    logic [2:0]      r_idx, w_idx_n;
    logic            r_stop, w_stop_n;
    logic [7:0]      r_shift, w_shift_n;
    logic            r_serial, w_serial_n;
    logic            r_busy, w_busy_n;
    logic            r_flag, w_flag_n;

    logic            w_tc;
    logic            w_accept;
    logic            w_set_flag;

    assign w_tc = (r_timer == TIMER_LAST);

    // State, counter and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_idx    <= '0;
            r_stop   <= 1'b0;
            r_shift  <= '0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
            r_flag   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_timer  <= w_timer_n;
            r_idx    <= w_idx_n;
            r_stop   <= w_stop_n;
            r_shift  <= w_shift_n;
            r_serial <= w_serial_n;
            r_busy   <= w_busy_n;
            r_flag   <= w_flag_n;
        end
    end

    // Next-state logic: the line level and busy for the coming cycle are
    // decided here so that they change on the same edge as the state.
    always_comb begin
        w_state_n  = r_state;
        w_timer_n  = r_timer;
        w_idx_n    = r_idx;
        w_stop_n   = r_stop;
        w_shift_n  = r_shift;
        w_serial_n = r_serial;
        w_busy_n   = r_busy;
        w_accept   = 1'b0;
        w_set_flag = 1'b0;

        if (r_state != S_IDLE) begin
            w_timer_n = w_tc ? '0 : r_timer + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_timer_n  = '0;
                w_serial_n = 1'b1;
                w_busy_n   = 1'b0;
                if (load) begin
                    w_accept   = 1'b1;
                    w_shift_n  = data;
                    w_idx_n    = '0;
                    w_stop_n   = 1'b0;
                    w_serial_n = 1'b0;
                    w_busy_n   = 1'b1;
                    w_state_n  = S_START;
                end
            end
            S_START: begin
                if (w_tc) begin
                    w_serial_n = r_shift[0];
                    w_idx_n    = '0;
                    w_state_n  = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tc) begin
                    w_shift_n = r_shift >> 1;
                    if (r_idx == 3'd7) begin
                        w_serial_n = 1'b1;
                        w_stop_n   = 1'b0;
                        w_state_n  = S_STOP;
                    end else begin
                        // Next bit is read one position up, ahead of the shift.
                        w_serial_n = r_shift[1];
                        w_idx_n    = r_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_tc) begin
                    if (!r_stop) begin
                        w_stop_n = 1'b1;
                    end else begin
                        w_stop_n   = 1'b0;
                        w_serial_n = 1'b1;
                        w_busy_n   = 1'b0;
                        w_set_flag = 1'b1;
                        w_state_n  = S_IDLE;
                    end
                end
            end
            default: begin
                w_serial_n = 1'b1;
                w_busy_n   = 1'b0;
                w_state_n  = S_IDLE;
            end
        endcase

        // Completion wins over a coincident clear so no character is lost.
        if (w_set_flag) begin
            w_flag_n = 1'b1;
        end else if (w_accept || clear_flag) begin
            w_flag_n = 1'b0;
        end else begin
            w_flag_n = r_flag;
        end
    end

    assign serial_out = r_serial;
    assign busy       = r_busy;
    assign flag       = r_flag;

endmodule
